// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO controller: WIDTH pins with per-bit direction, synchronised
// inputs, per-bit edge/level interrupts with polarity select, and a
// write-1-to-clear interrupt status register.
//
// Ports:
//   clk_i, rst_i          system clock; asynchronous active-high reset
//   cyc_i, stb_i, we_i    Wishbone cycle / strobe / write enable
//   adr_i[2:0]            register word index
//   dat_i, dat_o          write data in; registered read data out
//   ack_o                 registered acknowledge, one per access, 1 wait state
//   gpio_i                pin inputs, asynchronous to clk_i
//   gpio_o, gpio_oe       pin output values and output enables (1 = drive)
//   irq_o                 level interrupt, high while any enabled status bit set
//
// Latency: pin change to status bit is SYNC_STAGES + 1 clocks.
// Backpressure: none; every access is acked exactly one cycle after the strobe.
module wb_gpio_ctrl #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [2:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  localparam logic [2:0] ADR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADR_DIR      = 3'd2;
  localparam logic [2:0] ADR_IRQ_EN   = 3'd3;
  localparam logic [2:0] ADR_IRQ_EDGE = 3'd4;
  localparam logic [2:0] ADR_IRQ_POL  = 3'd5;
  localparam logic [2:0] ADR_IRQ_STAT = 3'd6;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_irq_edge;
  logic [WIDTH-1:0] r_irq_pol;
  logic [WIDTH-1:0] r_irq_stat;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_hit;
  logic [WIDTH-1:0] w_lvl_hit;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rd_dat;
  logic             w_access;
  logic             w_wr;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  // Polarity 1 selects rising edge / high level, 0 selects falling / low.
  assign w_edge_hit = (w_rise & r_irq_pol) | (w_fall & ~r_irq_pol);
  assign w_lvl_hit  = ~(w_sync ^ r_irq_pol);
  assign w_set      = r_irq_en & ((r_irq_edge & w_edge_hit) | (~r_irq_edge & w_lvl_hit));

  // The ~ack_o term makes a held strobe produce one ack every other cycle.
  assign w_access = cyc_i & stb_i & ~ack_o;
  assign w_wr     = w_access & we_i;
  assign w_w1c    = (w_wr && (adr_i == ADR_IRQ_STAT)) ? dat_i : '0;

  always_comb begin
    w_rd_dat = '0;
    case (adr_i)
      ADR_DATA_IN:  w_rd_dat = w_sync;
      ADR_DATA_OUT: w_rd_dat = r_data_out;
      ADR_DIR:      w_rd_dat = r_dir;
      ADR_IRQ_EN:   w_rd_dat = r_irq_en;
      ADR_IRQ_EDGE: w_rd_dat = r_irq_edge;
      ADR_IRQ_POL:  w_rd_dat = r_irq_pol;
      ADR_IRQ_STAT: w_rd_dat = r_irq_stat;
      default:      w_rd_dat = '0;
    endcase
  end

  // Input synchroniser and previous-value register for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync;
    end
  end

  // Bus side: ack, read data and the RW registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o      <= 1'b0;
      dat_o      <= '0;
      r_data_out <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_irq_edge <= '0;
      r_irq_pol  <= '0;
    end else begin
      ack_o <= w_access;
      if (w_access) begin
        dat_o <= w_rd_dat;
      end
      if (w_wr) begin
        case (adr_i)
          ADR_DATA_OUT: r_data_out <= dat_i;
          ADR_DIR:      r_dir      <= dat_i;
          ADR_IRQ_EN:   r_irq_en   <= dat_i;
          ADR_IRQ_EDGE: r_irq_edge <= dat_i;
          ADR_IRQ_POL:  r_irq_pol  <= dat_i;
          default:      ;
        endcase
      end
    end
  end

  // Status: OR-ing the set term in after the clear lets a new event win over
  // a simultaneous W1C, and keeps a persisting level from being cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_stat <= '0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_set;
    end
  end

  assign gpio_o  = r_data_out;
  assign gpio_oe = r_dir;
  assign irq_o   = |(r_irq_stat & r_irq_en);

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Testbench for wb_gpio_ctrl: directed scenarios plus randomized bus and pin
// traffic, every cycle compared against a behavioural reference model.
// Latency/backpressure: n/a (bench).
module tb_wb_gpio_ctrl;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [2:0]   adr;
  logic [W-1:0] wdat;
  logic [W-1:0] rdat;
  logic         ack;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] m_out, m_dir, m_en, m_edge, m_pol, m_stat, m_dat;
  logic         m_ack;
  logic [W-1:0] hist[$];  // pin samples, newest first

  wb_gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .dat_i   (wdat),
    .dat_o   (rdat),
    .ack_o   (ack),
    .gpio_i  (gpio_in),
    .gpio_o  (gpio_out),
    .gpio_oe (gpio_oe),
    .irq_o   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pol = '0;
    m_stat = '0; m_dat = '0; m_ack = 1'b0;
    hist.delete();
    repeat (S + 1) hist.push_back('0);
  endtask

  function automatic logic [W-1:0] model_rd(input logic [2:0] a, input logic [W-1:0] pins);
    case (a)
      3'd0:    return pins;
      3'd1:    return m_out;
      3'd2:    return m_dir;
      3'd3:    return m_en;
      3'd4:    return m_edge;
      3'd5:    return m_pol;
      3'd6:    return m_stat;
      default: return '0;
    endcase
  endfunction

  // One clock: advance the model by the register-map rules, then compare.
  task automatic tick();
    logic [W-1:0] cur, old, setv, clr;
    logic         acc;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      cur  = hist[S-1];  // synchronised pin value seen this cycle
      old  = hist[S];    // synchronised value one cycle earlier
      setv = '0;
      for (int n = 0; n < W; n++) begin
        if (m_en[n]) begin
          if (m_edge[n]) setv[n] = m_pol[n] ? (cur[n] && !old[n]) : (!cur[n] && old[n]);
          else           setv[n] = (cur[n] == m_pol[n]);
        end
      end
      acc = cyc && stb && !m_ack;
      clr = '0;
      if (acc) begin
        m_dat = model_rd(adr, cur);
        if (we) begin
          case (adr)
            3'd1: m_out  = wdat;
            3'd2: m_dir  = wdat;
            3'd3: m_en   = wdat;
            3'd4: m_edge = wdat;
            3'd5: m_pol  = wdat;
            3'd6: clr    = wdat;
            default: ;
          endcase
        end
      end
      m_stat = (m_stat & ~clr) | setv;
      m_ack  = acc;
      hist.push_front(gpio_in);
      void'(hist.pop_back());
    end
    #1;
    chk("ack", ack, m_ack);
    chk("dat_o", rdat, m_dat);
    chk("gpio_o", gpio_out, m_out);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("irq", irq, |(m_stat & m_en));
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [W-1:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    tick();
    chk("wr_ack_rise", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk("wr_ack_fall", ack, 1'b0);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [W-1:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    tick();
    chk("rd_ack_rise", ack, 1'b1);
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("rd_ack_fall", ack, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rv;
    int           op;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; gpio_in = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("por_oe", gpio_oe, 16'h0000);
    chk("por_irq", irq, 1'b0);

    // Direction and output data, with readback.
    wb_write(3'd2, 16'h00FF);
    wb_write(3'd1, 16'hA5A5);
    chk("dir_oe", gpio_oe, 16'h00FF);
    chk("data_out", gpio_out, 16'hA5A5);
    wb_read(3'd2, rv); chk("rd_dir", rv, 16'h00FF);
    wb_read(3'd1, rv); chk("rd_dout", rv, 16'hA5A5);
    wb_write(3'd0, 16'h1234);  // read-only, ignored
    wb_write(3'd7, 16'h1234);  // reserved, ignored
    wb_read(3'd7, rv); chk("rd_rsvd", rv, 16'h0000);

    // Rising edge on bit 0 appears three clocks after the pin change.
    wb_write(3'd4, 16'h0001);
    wb_write(3'd5, 16'h0001);
    wb_write(3'd3, 16'h0001);
    gpio_in = 16'h0001;
    tick(); tick();
    chk("edge_not_yet", irq, 1'b0);
    tick();
    chk("edge_irq", irq, 1'b1);
    wb_read(3'd6, rv); chk("edge_stat", rv, 16'h0001);
    wb_read(3'd0, rv); chk("data_in", rv, 16'h0001);
    wb_write(3'd6, 16'h0001);
    chk("w1c_irq", irq, 1'b0);
    repeat (4) tick();
    wb_read(3'd6, rv); chk("no_retrigger", rv, 16'h0000);

    // Level-low on bit 3 cannot be cleared while the pin stays low.
    wb_write(3'd3, 16'h0009);
    wb_write(3'd6, 16'h0008);
    wb_read(3'd6, rv); chk("lvl_sticky", rv, 16'h0008);
    gpio_in = 16'h0009;
    repeat (4) tick();
    wb_write(3'd6, 16'h0008);
    wb_read(3'd6, rv); chk("lvl_cleared", rv, 16'h0000);

    // Edge on bit 0 lands on the same edge as its W1C: set wins.
    gpio_in = 16'h0008;
    repeat (4) tick();
    gpio_in = 16'h0009;
    tick(); tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd6; wdat = 16'h0001;
    tick();
    chk("race_irq", irq, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    wb_read(3'd6, rv); chk("race_stat", rv, 16'h0001);
    wb_write(3'd6, 16'h0001);

    // Disabling an enable masks irq but keeps the status bit.
    gpio_in = 16'h0001;
    repeat (4) tick();
    chk("mask_pre_irq", irq, 1'b1);
    wb_write(3'd3, 16'h0001);
    chk("mask_irq", irq, 1'b0);
    wb_read(3'd6, rv); chk("mask_stat", rv, 16'h0008);
    wb_write(3'd3, 16'h0009);
    chk("unmask_irq", irq, 1'b1);
    gpio_in = 16'h0009;
    repeat (4) tick();
    wb_write(3'd6, 16'hFFFF);

    // Randomized traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
      op = $urandom_range(0, 9);
      if (op < 4) begin
        wb_write(3'($urandom_range(0, 7)), W'($urandom));
      end else if (op < 7) begin
        wb_read(3'($urandom_range(0, 7)), rv);
      end else if (op == 7) begin
        cyc = 1'b1; stb = 1'b1; we = 1'($urandom); adr = 3'($urandom); wdat = W'($urandom);
        repeat ($urandom_range(2, 5)) tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
      end else begin
        tick();
      end
    end

    // Reset in the middle of a write with irq asserted.
    gpio_in = '0;
    wb_write(3'd2, 16'hFFFF);
    wb_write(3'd4, 16'h0000);
    wb_write(3'd5, 16'h0000);
    wb_write(3'd3, 16'hFFFF);
    repeat (4) tick();
    chk("pre_rst_irq", irq, 1'b1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; wdat = 16'h5A5A;
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_oe", gpio_oe, 16'h0000);
    chk("rst_irq", irq, 1'b0);
    chk("rst_dat", rdat, 16'h0000);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), rv);
      chk("rst_rd", rv, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
